// File: rtl/pe_dma_sched.sv
// ============================================================================
//  Module   : pe_dma_sched
//  Brief    : PE DMA sequencer. Latches the APB-programmed transfer on a
//             rising start edge, checks it, then splits it into bursts of at
//             most MAX_BURST words. Each burst is one read command followed
//             by the matching write command, with one command outstanding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_dma_sched #(
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] dma_src_addr_i,
    input  logic [ADDR_W-1:0] dma_dst_addr_i,
    input  logic [31:0]       dma_size_i,
    input  logic [31:0]       dma_stride_i,
    input  logic [2:0]        dma_mode_i,
    input  logic              dma_start_i,
    output logic              rd_cmd_valid_o,
    input  logic              rd_cmd_ready_i,
    output logic [ADDR_W-1:0] rd_cmd_addr_o,
    output logic [LEN_W-1:0]  rd_cmd_len_o,
    input  logic              rd_resp_valid_i,
    input  logic              rd_resp_err_i,
    output logic              wr_cmd_valid_o,
    input  logic              wr_cmd_ready_i,
    output logic [ADDR_W-1:0] wr_cmd_addr_o,
    output logic [LEN_W-1:0]  wr_cmd_len_o,
    input  logic              wr_resp_valid_i,
    input  logic              wr_resp_err_i,
    output logic              dma_busy_o,
    output logic              dma_done_o,
    output logic              dma_error_o
);

    // Remaining word count: a 32-bit byte size holds at most 2^30 words.
    localparam int                 REM_W      = 30;
    localparam logic [REM_W-1:0]   MAX_REM    = REM_W'(MAX_BURST);
    localparam logic [LEN_W-1:0]   MAX_LEN    = LEN_W'(MAX_BURST);

    localparam logic [1:0] MODE_LINEAR  = 2'b00;
    localparam logic [1:0] MODE_SRC_STR = 2'b01;
    localparam logic [1:0] MODE_DST_STR = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CHECK   = 4'd1,
        S_RD_REQ  = 4'd2,
        S_RD_WAIT = 4'd3,
        S_WR_REQ  = 4'd4,
        S_WR_WAIT = 4'd5,
        S_NEXT    = 4'd6,
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    state_t            state_q, state_d;
    logic              start_q;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [31:0]       size_q, size_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [1:0]        mode_q, mode_d;
    logic [REM_W-1:0]  rem_q, rem_d;

    logic              start_pulse;
    logic              cfg_bad;
    logic [LEN_W-1:0]  blen;
    logic [REM_W-1:0]  blen_words;
    logic [ADDR_W-1:0] blen_bytes;

    // Bit 0 of the mode field is a start alias handled by the register block.
    logic unused_mode_bit0;
    assign unused_mode_bit0 = dma_mode_i[0];

    assign start_pulse = dma_start_i & ~start_q;

    // Current burst size, derived from the working remaining count.
    assign blen       = (rem_q >= MAX_REM) ? MAX_LEN : rem_q[LEN_W-1:0];
    assign blen_words = {{(REM_W-LEN_W){1'b0}}, blen};
    assign blen_bytes = {{(ADDR_W-LEN_W-2){1'b0}}, blen, 2'b00};

    assign cfg_bad = (size_q == 32'd0) || (size_q[1:0] != 2'b00) ||
                     (mode_q == MODE_RSVD) ||
                     (src_q[1:0] != 2'b00) || (dst_q[1:0] != 2'b00);

    // State, working registers and start-edge history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            size_q   <= '0;
            stride_q <= '0;
            mode_q   <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= dma_start_i;
            src_q    <= src_d;
            dst_q    <= dst_d;
            size_q   <= size_d;
            stride_q <= stride_d;
            mode_q   <= mode_d;
            rem_q    <= rem_d;
        end
    end

    // Next-state and working-register update for the burst sequencer.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        size_d   = size_q;
        stride_d = stride_q;
        mode_d   = mode_q;
        rem_d    = rem_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_pulse) begin
                    src_d    = dma_src_addr_i;
                    dst_d    = dma_dst_addr_i;
                    size_d   = dma_size_i;
                    stride_d = dma_stride_i[ADDR_W-1:0];
                    mode_d   = dma_mode_i[2:1];
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cfg_bad) begin
                    state_d = S_ERR;
                end else begin
                    rem_d   = size_q[31:2];
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (rd_cmd_ready_i) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rd_resp_valid_i) state_d = rd_resp_err_i ? S_ERR : S_WR_REQ;
            end
            S_WR_REQ: begin
                if (wr_cmd_ready_i) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (wr_resp_valid_i) state_d = wr_resp_err_i ? S_ERR : S_NEXT;
            end
            S_NEXT: begin
                rem_d = rem_q - blen_words;
                case (mode_q)
                    MODE_SRC_STR: begin
                        src_d = src_q + stride_q;
                        dst_d = dst_q + blen_bytes;
                    end
                    MODE_DST_STR: begin
                        src_d = src_q + blen_bytes;
                        dst_d = dst_q + stride_q;
                    end
                    default: begin
                        src_d = src_q + blen_bytes;
                        dst_d = dst_q + blen_bytes;
                    end
                endcase
                state_d = (rem_d == '0) ? S_DONE : S_RD_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // MODE_LINEAR is the default arm above; named here for readability only.
    logic unused_mode_linear;
    assign unused_mode_linear = (mode_q == MODE_LINEAR);

    assign rd_cmd_valid_o = (state_q == S_RD_REQ);
    assign rd_cmd_addr_o  = src_q;
    assign rd_cmd_len_o   = blen;
    assign wr_cmd_valid_o = (state_q == S_WR_REQ);
    assign wr_cmd_addr_o  = dst_q;
    assign wr_cmd_len_o   = blen;

    assign dma_busy_o  = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign dma_done_o  = (state_q == S_DONE);
    assign dma_error_o = (state_q == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_pe_dma_sched.sv
// ============================================================================
//  Module   : tb_pe_dma_sched
//  Brief    : Directed self-checking bench for pe_dma_sched with a simple
//             memory-side responder (optional read stall / read error).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_dma_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dma_src_addr, dma_dst_addr, dma_size, dma_stride;
    logic [2:0]  dma_mode;
    logic        dma_start;
    logic        rd_cmd_valid, rd_cmd_ready, rd_resp_valid, rd_resp_err;
    logic [31:0] rd_cmd_addr;
    logic [4:0]  rd_cmd_len;
    logic        wr_cmd_valid, wr_cmd_ready, wr_resp_valid, wr_resp_err;
    logic [31:0] wr_cmd_addr;
    logic [4:0]  wr_cmd_len;
    logic        dma_busy, dma_done, dma_error;

    int vectors = 0;
    int miscompares = 0;

    // responder observations
    bit          finished, overlap_seen, unstable_seen, hold_start;
    int          rd_hs, wr_hs, rd_stall_cycles;
    logic [31:0] rd_addr_a[4], wr_addr_a[4];
    logic [4:0]  rd_len_a[4], wr_len_a[4];

    always #5 clk = ~clk;

    pe_dma_sched dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dma_src_addr_i (dma_src_addr),
        .dma_dst_addr_i (dma_dst_addr),
        .dma_size_i     (dma_size),
        .dma_stride_i   (dma_stride),
        .dma_mode_i     (dma_mode),
        .dma_start_i    (dma_start),
        .rd_cmd_valid_o (rd_cmd_valid),
        .rd_cmd_ready_i (rd_cmd_ready),
        .rd_cmd_addr_o  (rd_cmd_addr),
        .rd_cmd_len_o   (rd_cmd_len),
        .rd_resp_valid_i(rd_resp_valid),
        .rd_resp_err_i  (rd_resp_err),
        .wr_cmd_valid_o (wr_cmd_valid),
        .wr_cmd_ready_i (wr_cmd_ready),
        .wr_cmd_addr_o  (wr_cmd_addr),
        .wr_cmd_len_o   (wr_cmd_len),
        .wr_resp_valid_i(wr_resp_valid),
        .wr_resp_err_i  (wr_resp_err),
        .dma_busy_o     (dma_busy),
        .dma_done_o     (dma_done),
        .dma_error_o    (dma_error)
    );

    // Called at a negedge with dma_start low; returns one negedge after the
    // start-sampling edge (edge 1).
    task automatic do_start(input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] size, input logic [31:0] stride,
                            input logic [2:0] mode);
        dma_src_addr = src;
        dma_dst_addr = dst;
        dma_size     = size;
        dma_stride   = stride;
        dma_mode     = mode;
        dma_start    = 1'b1;
        @(negedge clk);
        dma_start    = hold_start;
        // scramble the inputs: the running transfer must not follow them
        dma_src_addr = 32'hBAD0_0000;
        dma_dst_addr = 32'hBAD1_0000;
        dma_size     = 32'h0000_0006;
        dma_mode     = 3'b110;
    endtask

    // Memory-side responder: accepts commands (optionally stalling reads),
    // answers each one a cycle after its handshake, logs every command.
    task automatic run_xfer(input int rd_stall, input int err_burst,
                            input int retrig_cycle, input bit stop_wr,
                            input int max_cycles);
        int stall_cnt = 0;
        bit pend_rd = 0, pend_wr = 0, holding = 0;
        logic [31:0] h_addr = '0;
        logic [4:0]  h_len = '0;
        finished = 0; overlap_seen = 0; unstable_seen = 0;
        rd_hs = 0; wr_hs = 0; rd_stall_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            rd_addr_a[i] = 32'hDEAD_BEEF; wr_addr_a[i] = 32'hDEAD_BEEF;
            rd_len_a[i] = 5'h1F; wr_len_a[i] = 5'h1F;
        end
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (!dma_busy && (dma_done || dma_error)) begin
                finished = 1;
                break;
            end
            if (rd_cmd_valid && wr_cmd_valid) overlap_seen = 1;
            rd_resp_valid = pend_rd;
            rd_resp_err   = pend_rd && (rd_hs == err_burst);
            wr_resp_valid = pend_wr;
            wr_resp_err   = 1'b0;
            pend_rd = 0;
            pend_wr = 0;
            rd_cmd_ready = 1'b0;
            wr_cmd_ready = 1'b0;
            if (rd_cmd_valid) begin
                if (!holding) begin
                    h_addr = rd_cmd_addr; h_len = rd_cmd_len; holding = 1;
                end else if (rd_cmd_addr !== h_addr || rd_cmd_len !== h_len) begin
                    unstable_seen = 1;
                end
                if (stall_cnt >= rd_stall) begin
                    rd_cmd_ready = 1'b1;
                    if (rd_hs < 4) begin
                        rd_addr_a[rd_hs] = rd_cmd_addr; rd_len_a[rd_hs] = rd_cmd_len;
                    end
                    rd_hs++;
                    pend_rd = 1; stall_cnt = 0; holding = 0;
                end else begin
                    stall_cnt++;
                    rd_stall_cycles++;
                end
            end
            if (wr_cmd_valid) begin
                wr_cmd_ready = 1'b1;
                if (wr_hs < 4) begin
                    wr_addr_a[wr_hs] = wr_cmd_addr; wr_len_a[wr_hs] = wr_cmd_len;
                end
                wr_hs++;
                pend_wr = 1;
            end
            dma_start = hold_start | (cyc == retrig_cycle);
            @(negedge clk);
            if (stop_wr && pend_wr) break;
        end
        rd_cmd_ready = 0; wr_cmd_ready = 0;
        rd_resp_valid = 0; rd_resp_err = 0;
        wr_resp_valid = 0; wr_resp_err = 0;
        dma_start = hold_start;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (dma_busy !== 1'b0 || dma_done !== 1'b0 || dma_error !== 1'b0) begin
            miscompares++; $display("FAIL reset_status: got busy/done/err %b%b%b want 000", dma_busy, dma_done, dma_error); end
        vectors++; if (rd_cmd_valid !== 1'b0 || wr_cmd_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid: got rd/wr %b%b want 00", rd_cmd_valid, wr_cmd_valid); end
        vectors++; if (rd_cmd_addr !== 32'h0 || rd_cmd_len !== 5'd0 || wr_cmd_addr !== 32'h0 || wr_cmd_len !== 5'd0) begin
            miscompares++; $display("FAIL reset_cmd: got rd %h/%0d wr %h/%0d want zeros", rd_cmd_addr, rd_cmd_len, wr_cmd_addr, wr_cmd_len); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (dma_busy !== 1'b0 || rd_cmd_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_idle: got busy %b rd_valid %b want 0 0", dma_busy, rd_cmd_valid); end
    endtask

    task automatic test_linear();
        do_start(32'h1000, 32'h2000, 32'd64, 32'h0, 3'b000);
        vectors++; if (dma_busy !== 1'b1 || rd_cmd_valid !== 1'b0) begin
            miscompares++; $display("FAIL linear_edge1: got busy %b rd_valid %b want 1 0", dma_busy, rd_cmd_valid); end
        @(negedge clk);
        vectors++; if (rd_cmd_valid !== 1'b1 || rd_cmd_addr !== 32'h1000 || rd_cmd_len !== 5'd16) begin
            miscompares++; $display("FAIL linear_edge2: got valid %b addr %h len %0d want 1 1000 16", rd_cmd_valid, rd_cmd_addr, rd_cmd_len); end
        run_xfer(0, 0, -1, 0, 100);
        vectors++; if (finished !== 1'b1 || dma_done !== 1'b1 || dma_error !== 1'b0) begin
            miscompares++; $display("FAIL linear_done: got fin %b done %b err %b want 1 1 0", finished, dma_done, dma_error); end
        vectors++; if (rd_hs != 1 || wr_hs != 1) begin
            miscompares++; $display("FAIL linear_count: got rd %0d wr %0d want 1 1", rd_hs, wr_hs); end
        vectors++; if (rd_addr_a[0] !== 32'h1000 || rd_len_a[0] !== 5'd16 || wr_addr_a[0] !== 32'h2000 || wr_len_a[0] !== 5'd16) begin
            miscompares++; $display("FAIL linear_cmds: got rd %h/%0d wr %h/%0d want 1000/16 2000/16", rd_addr_a[0], rd_len_a[0], wr_addr_a[0], wr_len_a[0]); end
        vectors++; if (overlap_seen !== 1'b0) begin
            miscompares++; $display("FAIL linear_overlap: got %b want 0", overlap_seen); end
    endtask

    typedef struct {
        logic [31:0] src, dst, size, stride;
        logic [2:0]  mode;
        int          nb;
        logic [31:0] ra0, ra1, wa0, wa1;
        logic [4:0]  l0, l1;
    } pat_t;

    task automatic test_bursts();
        pat_t p[6];
        logic [31:0] era, ewa;
        logic [4:0]  el;
        p[0] = '{32'h1000, 32'h2000, 32'h50, 32'h0,   3'b000, 2, 32'h1000, 32'h1040, 32'h2000, 32'h2040, 5'd16, 5'd4};
        p[1] = '{32'h1000, 32'h2000, 32'h80, 32'h100, 3'b010, 2, 32'h1000, 32'h1100, 32'h2000, 32'h2040, 5'd16, 5'd16};
        p[2] = '{32'h1000, 32'h2000, 32'h50, 32'h80,  3'b100, 2, 32'h1000, 32'h1040, 32'h2000, 32'h2080, 5'd16, 5'd4};
        p[3] = '{32'hFFFF_FFC0, 32'h3000, 32'h80, 32'h0, 3'b000, 2, 32'hFFFF_FFC0, 32'h0, 32'h3000, 32'h3040, 5'd16, 5'd16};
        p[4] = '{32'h1000, 32'h2000, 32'h60, 32'h0,   3'b011, 2, 32'h1000, 32'h1000, 32'h2000, 32'h2040, 5'd16, 5'd8};
        p[5] = '{32'h1000, 32'h2000, 32'h4,  32'h0,   3'b000, 1, 32'h1000, 32'h0,    32'h2000, 32'h0,    5'd1,  5'd0};
        for (int k = 0; k < 6; k++) begin
            do_start(p[k].src, p[k].dst, p[k].size, p[k].stride, p[k].mode);
            run_xfer(0, 0, -1, 0, 200);
            vectors++; if (finished !== 1'b1 || dma_done !== 1'b1 || dma_error !== 1'b0) begin
                miscompares++; $display("FAIL burst%0d_done: got fin %b done %b err %b want 1 1 0", k, finished, dma_done, dma_error); end
            vectors++; if (rd_hs != p[k].nb || wr_hs != p[k].nb || overlap_seen) begin
                miscompares++; $display("FAIL burst%0d_count: got rd %0d wr %0d ovl %b want %0d %0d 0", k, rd_hs, wr_hs, overlap_seen, p[k].nb, p[k].nb); end
            for (int b = 0; b < p[k].nb; b++) begin
                era = (b == 0) ? p[k].ra0 : p[k].ra1;
                ewa = (b == 0) ? p[k].wa0 : p[k].wa1;
                el  = (b == 0) ? p[k].l0  : p[k].l1;
                vectors++; if (rd_addr_a[b] !== era || rd_len_a[b] !== el || wr_addr_a[b] !== ewa || wr_len_a[b] !== el) begin
                    miscompares++; $display("FAIL burst%0d_cmd%0d: got rd %h/%0d wr %h/%0d want rd %h/%0d wr %h/%0d", k, b,
                        rd_addr_a[b], rd_len_a[b], wr_addr_a[b], wr_len_a[b], era, el, ewa, el); end
            end
        end
    endtask

    task automatic test_cfg_errors();
        logic [31:0] src[5] = '{32'h1000, 32'h1000, 32'h1000, 32'h1002, 32'h1000};
        logic [31:0] dst[5] = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h2001};
        logic [31:0] sz[5]  = '{32'd6, 32'd0, 32'd64, 32'd64, 32'd64};
        logic [2:0]  md[5]  = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000};
        bit rd_seen;
        for (int k = 0; k < 5; k++) begin
            do_start(src[k], dst[k], sz[k], 32'h0, md[k]);
            vectors++; if (dma_busy !== 1'b1 || dma_error !== 1'b0 || dma_done !== 1'b0) begin
                miscompares++; $display("FAIL cfgerr%0d_edge1: got busy %b err %b done %b want 1 0 0", k, dma_busy, dma_error, dma_done); end
            @(negedge clk);
            vectors++; if (dma_error !== 1'b1 || dma_busy !== 1'b0 || dma_done !== 1'b0) begin
                miscompares++; $display("FAIL cfgerr%0d_edge2: got err %b busy %b done %b want 1 0 0", k, dma_error, dma_busy, dma_done); end
            rd_seen = rd_cmd_valid;
            repeat (4) begin @(negedge clk); rd_seen |= rd_cmd_valid; end
            vectors++; if (rd_seen !== 1'b0) begin
                miscompares++; $display("FAIL cfgerr%0d_nocmd: got rd_valid seen %b want 0", k, rd_seen); end
        end
    endtask

    task automatic test_rd_error();
        bit wr_seen = 0;
        do_start(32'h1000, 32'h2000, 32'h80, 32'h0, 3'b000);
        run_xfer(0, 2, -1, 0, 200);
        vectors++; if (finished !== 1'b1 || dma_error !== 1'b1 || dma_done !== 1'b0) begin
            miscompares++; $display("FAIL rderr_status: got fin %b err %b done %b want 1 1 0", finished, dma_error, dma_done); end
        vectors++; if (rd_hs != 2 || wr_hs != 1) begin
            miscompares++; $display("FAIL rderr_count: got rd %0d wr %0d want 2 1", rd_hs, wr_hs); end
        repeat (5) begin @(negedge clk); wr_seen |= wr_cmd_valid | rd_cmd_valid; end
        vectors++; if (wr_seen !== 1'b0) begin
            miscompares++; $display("FAIL rderr_quiet: got cmd seen %b want 0", wr_seen); end
    endtask

    task automatic test_backpressure();
        do_start(32'h1000, 32'h2000, 32'd64, 32'h0, 3'b000);
        run_xfer(5, 0, -1, 0, 200);
        vectors++; if (finished !== 1'b1 || dma_done !== 1'b1) begin
            miscompares++; $display("FAIL bp_done: got fin %b done %b want 1 1", finished, dma_done); end
        vectors++; if (unstable_seen !== 1'b0 || rd_stall_cycles != 5 || rd_hs != 1) begin
            miscompares++; $display("FAIL bp_hold: got unstable %b stalls %0d hs %0d want 0 5 1", unstable_seen, rd_stall_cycles, rd_hs); end
        vectors++; if (rd_addr_a[0] !== 32'h1000 || rd_len_a[0] !== 5'd16) begin
            miscompares++; $display("FAIL bp_cmd: got %h/%0d want 1000/16", rd_addr_a[0], rd_len_a[0]); end
    endtask

    task automatic test_retrigger();
        do_start(32'h1000, 32'h2000, 32'h50, 32'h0, 3'b000);
        run_xfer(0, 0, 3, 0, 200);
        vectors++; if (finished !== 1'b1 || dma_done !== 1'b1 || rd_hs != 2) begin
            miscompares++; $display("FAIL retrig_run: got fin %b done %b rd %0d want 1 1 2", finished, dma_done, rd_hs); end
        vectors++; if (rd_addr_a[1] !== 32'h1040 || wr_addr_a[1] !== 32'h2040 || rd_len_a[1] !== 5'd4) begin
            miscompares++; $display("FAIL retrig_cmd: got rd %h wr %h len %0d want 1040 2040 4", rd_addr_a[1], wr_addr_a[1], rd_len_a[1]); end
    endtask

    task automatic test_hold_start();
        bit again = 0;
        hold_start = 1;
        do_start(32'h1000, 32'h2000, 32'd64, 32'h0, 3'b000);
        run_xfer(0, 0, -1, 0, 100);
        vectors++; if (finished !== 1'b1 || dma_done !== 1'b1) begin
            miscompares++; $display("FAIL hold_done: got fin %b done %b want 1 1", finished, dma_done); end
        repeat (10) begin @(negedge clk); again |= rd_cmd_valid | dma_busy | ~dma_done; end
        vectors++; if (again !== 1'b0) begin
            miscompares++; $display("FAIL hold_noretrig: got restart %b want 0", again); end
        hold_start = 0;
        dma_start = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        do_start(32'h1000, 32'h2000, 32'd64, 32'h0, 3'b000);
        run_xfer(0, 0, -1, 1, 100);
        vectors++; if (wr_hs != 1 || dma_busy !== 1'b1) begin
            miscompares++; $display("FAIL midrst_reach: got wr %0d busy %b want 1 1", wr_hs, dma_busy); end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (dma_busy !== 1'b0 || dma_done !== 1'b0 || dma_error !== 1'b0 || rd_cmd_valid !== 1'b0 || wr_cmd_valid !== 1'b0) begin
            miscompares++; $display("FAIL midrst_status: got b/d/e/rv/wv %b%b%b%b%b want 00000", dma_busy, dma_done, dma_error, rd_cmd_valid, wr_cmd_valid); end
        vectors++; if (rd_cmd_addr !== 32'h0 || rd_cmd_len !== 5'd0 || wr_cmd_addr !== 32'h0 || wr_cmd_len !== 5'd0) begin
            miscompares++; $display("FAIL midrst_cmd: got rd %h/%0d wr %h/%0d want zeros", rd_cmd_addr, rd_cmd_len, wr_cmd_addr, wr_cmd_len); end
        rst_n = 1'b1;
        @(negedge clk);
        do_start(32'h4000, 32'h5000, 32'd32, 32'h0, 3'b000);
        run_xfer(0, 0, -1, 0, 100);
        vectors++; if (finished !== 1'b1 || dma_done !== 1'b1 || rd_hs != 1 || wr_hs != 1) begin
            miscompares++; $display("FAIL midrst_rerun: got fin %b done %b rd %0d wr %0d want 1 1 1 1", finished, dma_done, rd_hs, wr_hs); end
        vectors++; if (rd_addr_a[0] !== 32'h4000 || wr_addr_a[0] !== 32'h5000 || rd_len_a[0] !== 5'd8 || wr_len_a[0] !== 5'd8) begin
            miscompares++; $display("FAIL midrst_cmds: got rd %h/%0d wr %h/%0d want 4000/8 5000/8", rd_addr_a[0], rd_len_a[0], wr_addr_a[0], wr_len_a[0]); end
    endtask

    initial begin
        hold_start = 0;
        rst_n = 1'b0;
        dma_src_addr = '0; dma_dst_addr = '0; dma_size = '0; dma_stride = '0;
        dma_mode = '0; dma_start = 1'b0;
        rd_cmd_ready = 0; rd_resp_valid = 0; rd_resp_err = 0;
        wr_cmd_ready = 0; wr_resp_valid = 0; wr_resp_err = 0;
        @(negedge clk);
        test_reset();
        test_linear();
        test_bursts();
        test_cfg_errors();
        test_rd_error();
        test_backpressure();
        test_retrigger();
        test_hold_start();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
